// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 framebuffer constants and scanout state encoding
package chip8_pkg;

    // Framebuffer geometry; the CPU uses the same values for CLS and DRW.
    localparam logic [11:0] FB_BASE_ADDR = 12'h100;
    localparam int          FB_WIDTH     = 64;
    localparam int          FB_HEIGHT    = 32;
    localparam int          FB_BYTES     = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT,
        ST_NEXT,
        ST_DONE
    } scan_state_t;

    // Byte address of framebuffer entry idx, computed at full 12-bit width.
    function automatic logic [11:0] fb_addr(input logic [11:0] base, input logic [8:0] idx);
        return base + {3'b000, idx};
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// rtl/spi_byte_tx.sv - SPI mode-0 byte transmitter, MSB first, divided SCK
module spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       sck,
    output logic       mosi
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active;
    logic [DW-1:0] div;
    logic [2:0]    bitcnt;
    logic [6:0]    shreg;     // bits still to be sent after the one on mosi
    logic          half_end;
    logic          last_edge;

    assign half_end  = active && (div == DIV_LAST);
    assign last_edge = half_end && sck && (bitcnt == 3'd7);
    // busy drops in the final cycle so the owner can move on without a dead cycle
    assign busy      = active && !last_edge;

    // Load presents bit 7 at once; each half-period toggles SCK and the data
    // advances only on the falling edge, keeping mosi stable while SCK is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            div    <= '0;
            bitcnt <= 3'd0;
            shreg  <= 7'd0;
            sck    <= 1'b0;
            mosi   <= 1'b0;
        end else if (load) begin
            active <= 1'b1;
            div    <= '0;
            bitcnt <= 3'd0;
            shreg  <= data[6:0];
            mosi   <= data[7];
            sck    <= 1'b0;
        end else if (active) begin
            if (half_end) begin
                div <= '0;
                if (!sck) begin
                    sck <= 1'b1;
                end else begin
                    sck <= 1'b0;
                    if (bitcnt == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        bitcnt <= bitcnt + 3'd1;
                        mosi   <= shreg[6];
                        shreg  <= {shreg[5:0], 1'b0};
                    end
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip8_fb_scanout.sv
// rtl/chip8_fb_scanout.sv - streams the CHIP-8 framebuffer from memory to an SPI display
module chip8_fb_scanout #(
    parameter logic [11:0] FB_BASE  = chip8_pkg::FB_BASE_ADDR,
    parameter int          FB_BYTES = chip8_pkg::FB_BYTES,
    parameter int          CLK_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_dc
);

    import chip8_pkg::*;

    localparam logic [8:0] LAST_IDX = 9'(FB_BYTES - 1);

    scan_state_t state;
    logic [8:0]  count;
    logic        tx_load;
    logic        tx_busy;

    // Read data is valid only in WAIT, so that is the one cycle the shifter loads.
    assign tx_load = (state == ST_WAIT);

    spi_byte_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .load (tx_load),
        .data (mem_data),
        .busy (tx_busy),
        .sck  (spi_sck),
        .mosi (spi_mosi)
    );

    // Frame sequencer: fetch one byte, hand it to the shifter, repeat until the last index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= 9'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= FB_BASE;
            spi_cs_n <= 1'b1;
            spi_dc   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= ST_FETCH;
                        count    <= 9'd0;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= FB_BASE;
                        spi_cs_n <= 1'b0;
                        spi_dc   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        mem_rd <= 1'b0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!tx_busy) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (count == LAST_IDX) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        spi_cs_n <= 1'b1;
                        spi_dc   <= 1'b0;
                    end else begin
                        count    <= count + 9'd1;
                        mem_addr <= fb_addr(FB_BASE, count + 9'd1);
                        mem_rd   <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_fb_scanout.sv
// tb/tb_chip8_fb_scanout.sv - self-checking bench for chip8_fb_scanout
module tb_chip8_fb_scanout;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_dc;

    always #5 clk = ~clk;

    chip8_fb_scanout #(
        .FB_BASE  (12'h100),
        .FB_BYTES (256),
        .CLK_DIV  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_dc    (spi_dc)
    );

    typedef struct {
        int fill;        // 0 all zero, 1 A5/3C at start, 2 0x01 in last byte
        int stall;       // hold mem_ready low 10 cycles in the 5th fetch
        int again_at;    // cycle at which start is pulsed again (0 = never)
        int exp_done;    // cycle (after start edge) in which done is seen
        int exp_ones;    // number of 1 bits on the link
    } case_t;

    case_t       cases [5];
    logic [7:0]  mem [0:4095];
    int          checks = 0;
    int          failures = 0;
    int          cyc, nbits, ones, ndone, done_cyc, cs_bad, mosi_bad;
    int          stall_left, stall_good, stall_armed, again_at;
    logic        sck_prev, mosi_prev, cyc1_ok;
    logic [11:0] max_addr;
    logic        bits [$];
    logic [11:0] addrs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int fill);
        for (int i = 0; i < 4096; i++) mem[i] = 8'hFF;
        for (int i = 12'h100; i < 12'h200; i++) mem[i] = 8'h00;
        if (fill == 1) begin
            mem[12'h100] = 8'hA5;
            mem[12'h101] = 8'h3C;
        end
        if (fill == 2) mem[12'h1FF] = 8'h01;
    endtask

    task automatic clear_stats();
        cyc = 0; nbits = 0; ones = 0; ndone = 0; done_cyc = 0;
        cs_bad = 0; mosi_bad = 0; stall_left = 0; stall_good = 0;
        stall_armed = 0; again_at = 0; max_addr = 12'h000; cyc1_ok = 1'b0;
        bits.delete();
        addrs.delete();
        sck_prev = spi_sck;
        mosi_prev = spi_mosi;
    endtask

    // One clock: memory model answers an accepted read, then the link is sampled #1 after the edge.
    task automatic tick();
        logic        acc;
        logic [11:0] a;
        acc = mem_rd && mem_ready;
        a = mem_addr;
        @(posedge clk);
        #1;
        mem_data = acc ? mem[a] : 8'($urandom);
        cyc++;
        start = (again_at != 0 && cyc == again_at);
        if (!rst) begin
            if (spi_sck && !sck_prev) begin
                nbits++;
                bits.push_back(spi_mosi);
                if (spi_mosi) ones++;
            end
            if (spi_sck && spi_mosi != mosi_prev) mosi_bad++;
            sck_prev = spi_sck;
            mosi_prev = spi_mosi;
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (acc) addrs.push_back(a);
            if (mem_rd && mem_addr > max_addr) max_addr = mem_addr;
            if (busy && !done && (spi_cs_n || !spi_dc)) cs_bad++;
            if (cyc == 1)
                cyc1_ok = busy && !spi_cs_n && spi_dc && mem_rd && (mem_addr == 12'h100) && !done;
            if (stall_armed != 0 && stall_left == 0 && mem_rd && mem_addr == 12'h104) begin
                mem_ready = 1'b0;
                stall_left = 10;
                stall_armed = 0;
            end
            if (stall_left > 0) begin
                if (mem_rd && mem_addr == 12'h104 && !spi_sck && !(spi_sck && !sck_prev)) stall_good++;
                stall_left--;
            end else if (!mem_ready) begin
                mem_ready = 1'b1;
            end
        end
    endtask

    task automatic run_case(input int idx, input case_t c);
        int          mism;
        int          idle_bad;
        logic [15:0] first16;
        fill_mem(c.fill);
        clear_stats();
        again_at = c.again_at;
        stall_armed = c.stall;
        mem_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 9300 && ndone == 0; i++) tick();
        check($sformatf("c%0d_done_cycle", idx), done_cyc, c.exp_done);
        tick();
        check($sformatf("c%0d_busy_after_done", idx), {31'd0, busy}, 0);
        idle_bad = 0;
        repeat (3) begin
            tick();
            if (busy || done || !spi_cs_n) idle_bad++;
        end
        check($sformatf("c%0d_idle_after", idx), idle_bad, 0);
        check($sformatf("c%0d_done_count", idx), ndone, 1);
        check($sformatf("c%0d_bit_count", idx), nbits, 2048);
        check($sformatf("c%0d_ones", idx), ones, c.exp_ones);
        check($sformatf("c%0d_max_addr", idx), {20'd0, max_addr}, 32'h1FF);
        check($sformatf("c%0d_cs_dc_bad", idx), cs_bad, 0);
        check($sformatf("c%0d_mosi_while_high", idx), mosi_bad, 0);
        check($sformatf("c%0d_first_fetch", idx), {31'd0, cyc1_ok}, 1);
        mism = 0;
        for (int k = 0; k < bits.size() && k < 2048; k++) begin
            logic [7:0] b;
            b = mem[12'h100 + k / 8];
            if (bits[k] !== b[7 - (k % 8)]) mism++;
        end
        check($sformatf("c%0d_bitstream", idx), mism, 0);
        mism = 0;
        for (int k = 0; k < addrs.size(); k++)
            if (addrs[k] != 12'(12'h100 + k)) mism++;
        check($sformatf("c%0d_addr_order", idx), mism, 0);
        check($sformatf("c%0d_addr_count", idx), addrs.size(), 256);
        if (c.stall != 0)
            check($sformatf("c%0d_stall_cycles", idx), stall_good, 10);
        if (c.fill == 1 && bits.size() >= 16) begin
            for (int k = 0; k < 16; k++) first16[15 - k] = bits[k];
            check($sformatf("c%0d_first16", idx), {16'd0, first16}, 32'h0000A53C);
        end
        if (c.fill == 2 && bits.size() > 0)
            check($sformatf("c%0d_last_bit", idx), {31'd0, bits[bits.size() - 1]}, 1);
    endtask

    initial begin
        cases[0] = '{fill: 0, stall: 0, again_at: 0,    exp_done: 8961, exp_ones: 0};
        cases[1] = '{fill: 1, stall: 0, again_at: 0,    exp_done: 8961, exp_ones: 8};
        cases[2] = '{fill: 0, stall: 1, again_at: 0,    exp_done: 8971, exp_ones: 0};
        cases[3] = '{fill: 0, stall: 0, again_at: 100,  exp_done: 8961, exp_ones: 0};
        cases[4] = '{fill: 2, stall: 0, again_at: 8961, exp_done: 8961, exp_ones: 1};

        rst = 1'b1;
        start = 1'b0;
        mem_ready = 1'b1;
        mem_data = 8'h00;
        fill_mem(0);
        clear_stats();
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_mem_rd", {31'd0, mem_rd}, 0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'h100);
        check("rst_sck", {31'd0, spi_sck}, 0);
        check("rst_mosi", {31'd0, spi_mosi}, 0);
        check("rst_cs_n", {31'd0, spi_cs_n}, 1);
        check("rst_dc", {31'd0, spi_dc}, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Reset in the middle of a frame, then a clean restart from the base address.
        fill_mem(1);
        clear_stats();
        start = 1'b1;
        while (cyc < 4000) tick();
        rst = 1'b1;
        #1;
        check("midrst_cs_n", {31'd0, spi_cs_n}, 1);
        check("midrst_sck", {31'd0, spi_sck}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_mem_rd", {31'd0, mem_rd}, 0);
        check("midrst_done_before", ndone, 0);
        repeat (2) tick();
        check("midrst_done_held", {31'd0, done}, 0);
        rst = 1'b0;
        tick();
        check("midrst_idle", {31'd0, busy}, 0);
        clear_stats();
        start = 1'b1;
        repeat (80) tick();
        check("restart_addr_count", addrs.size() >= 2 ? 1 : 0, 1);
        if (addrs.size() >= 2) begin
            check("restart_addr0", {20'd0, addrs[0]}, 32'h100);
            check("restart_addr1", {20'd0, addrs[1]}, 32'h101);
        end
        check("restart_no_done", ndone, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_case(i, cases[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chip8_fb_scanout.md
Name: chip8_fb_scanout

Overview:
Downstream consumer of the CHIP-8 CPU's framebuffer: 64x32 pixels, 1 bpp, 256 bytes at 0x100-0x1FF of main memory. On a frame request it reads the framebuffer bytes in ascending address order through a shared memory read port. It serialises each byte MSB-first over an SPI mode-0 link to the display controller. The CPU triggers it once per 60 Hz tick; the block arbitrates reads through a ready handshake and never writes memory.

Parameters:
- FB_BASE, 12'h100, first framebuffer byte address.
- FB_BYTES, 256, bytes per frame (1..256).
- CLK_DIV, 2, clk cycles per SCK half-period (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame request pulse, sampled in IDLE only.
- busy  output  1  high from the first cycle after an accepted start through DONE.
- done  output  1  one-cycle pulse when the frame is fully shifted out.
- mem_addr  output  12  framebuffer read address.
- mem_rd  output  1  read request.
- mem_ready  input  1  arbiter grant; a read is accepted in a cycle where mem_rd and mem_ready are both 1.
- mem_data  input  8  read data, valid exactly one cycle after acceptance.
- spi_sck  output  1  serial clock, idle low.
- spi_mosi  output  1  serial data, changes only while SCK is low.
- spi_cs_n  output  1  chip select, active low.
- spi_dc  output  1  data/command select, held 1 (data) while cs_n is low.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port rst.
- Reset values:
  - State IDLE; busy=0, done=0, mem_rd=0, mem_addr=FB_BASE.
  - spi_sck=0, spi_mosi=0, spi_cs_n=1, spi_dc=0.
  - Byte counter=0, divider=0.
- States: IDLE, FETCH, WAIT, SHIFT, NEXT, DONE.
- IDLE:
  - start=1 moves to FETCH and clears the byte counter.
  - cs_n falls and dc rises on entry to FETCH.
- FETCH:
  - mem_rd=1 and mem_addr=FB_BASE+count.
  - Stays in FETCH while mem_ready=0. No SCK activity; cs_n stays low.
  - Acceptance moves to WAIT.
- WAIT: latch mem_data into an 8-bit shift register, drive mosi with bit 7, then go to SHIFT.
- SHIFT:
  - 8 bits per byte; each bit is CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
  - The receiver samples on the SCK rising edge.
  - After a high half, SCK returns low and mosi advances to the next bit.
  - After bit 0's high half, go to NEXT.
- NEXT:
  - SCK is low.
  - If count==FB_BYTES-1, go to DONE; otherwise increment count and go to FETCH.
- DONE:
  - cs_n=1, dc=0, done=1 for one cycle, then IDLE.
  - busy drops in the IDLE cycle that follows.
- Latency with mem_ready=1 always: 2+8*2*CLK_DIV+1 cycles per byte.
  - CLK_DIV=2 gives 35 cycles per byte.
  - A full frame is 8960 cycles from the first FETCH to DONE inclusive of NEXT; done is asserted in cycle 8961.
- Width rules:
  - The counter is 9 bits, so FB_BYTES=256 terminates with no wrap.
  - mem_addr is computed in 12 bits and never exceeds FB_BASE+FB_BYTES-1.
- start asserted while busy, or during DONE, is ignored (not queued).
- Reset mid-frame: all outputs go to reset values immediately (async); no done pulse; the partial frame is abandoned.
- mem_data is ignored outside the WAIT cycle.

Decomposition:
- Shared package chip8_pkg:
  - State enum for the scanout FSM.
  - Constants FB_BASE_ADDR=12'h100, FB_WIDTH=64, FB_HEIGHT=32, FB_BYTES=256.
  - The CPU uses the same constants for CLS and DRW.
- One natural sub-module, spi_byte_tx: load/busy handshake, CLK_DIV divider, 8-bit MSB-first shifter, SCK/MOSI generation.
- chip8_fb_scanout keeps the fetch FSM, counter and memory handshake.

Test Plan:
- All-zero framebuffer, CLK_DIV=2, start pulse:
  - Exactly 2048 SCK rising edges, all sampled mosi=0.
  - cs_n low throughout; done pulse in cycle 8961 after start; busy=0 one cycle later.
- mem[0x100]=0xA5, mem[0x101]=0x3C:
  - First 16 sampled bits are 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - mem_addr sequence starts 0x100, 0x101.
- mem_ready held 0 for 10 cycles during the 5th FETCH:
  - mem_rd=1 with mem_addr=0x104 for all 10 cycles, no SCK edges.
  - After the grant, the stream resumes and the total frame is longer by exactly 10 cycles.
- start pulsed again at cycle 100 of a frame: ignored; exactly one done; 2048 bits total.
- rst asserted at cycle 4000:
  - Same-cycle cs_n=1, sck=0, busy=0, mem_rd=0; no done.
  - A new start afterwards restarts from address 0x100.
- mem[0x1FF]=0x01, others 0:
  - Last sampled bit =1, all others 0.
  - mem_addr never exceeds 0x1FF; done follows the last bit after NEXT.
